// File: rtl/data_mem_seq_if.sv
// Request/response bundle between a requester and data_mem_seq.
// The requester drives init_start and the request fields; the memory returns status and read data.
interface data_mem_seq_if #(
  parameter int W  = 8,
  parameter int AW = 3
) ();
  logic          init_start;
  logic          init_done;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_wdata;
  logic          rd_valid;
  logic [W-1:0]  rd_data;

  modport master (
    output init_start, req_valid, req_we, req_addr, req_wdata,
    input  init_done, req_ready, rd_valid, rd_data
  );

  modport slave (
    input  init_start, req_valid, req_we, req_addr, req_wdata,
    output init_done, req_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/data_mem_seq.sv
// Single-port data memory that fills itself with a fixed pattern after reset or on request,
// then serves valid/ready reads (1-cycle registered latency) and writes.
module data_mem_seq #(
  parameter int W         = 8,
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int INIT_MODE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_seq_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  state_t        state_r;
  state_t        state_s;
  logic [AW-1:0] cnt_r;
  logic [AW-1:0] cnt_s;
  logic [W-1:0]  mem_r [DEPTH];
  logic          mem_we_s;
  logic [AW-1:0] mem_waddr_s;
  logic [W-1:0]  mem_wdata_s;
  logic          req_ready_s;
  logic          addr_ok_s;
  logic          rd_load_s;
  logic [W-1:0]  rd_data_s;
  logic          rd_valid_r;
  logic [W-1:0]  rd_data_r;

  // Index truncated to W bits, zero-extended when W exceeds AW.
  function automatic logic [W-1:0] fill_pattern(input logic [AW-1:0] idx);
    logic [W-1:0] p;
    p = {W{1'b0}};
    for (int b = 0; b < W; b++) begin
      if (INIT_MODE == 1 && b < AW) begin
        p[b] = idx[b % AW];
      end else begin
        p[b] = 1'b0;
      end
    end
    return p;
  endfunction

  // Next-state, fill/write port selection and read capture.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    mem_we_s    = 1'b0;
    mem_waddr_s = bus.req_addr;
    mem_wdata_s = bus.req_wdata;
    req_ready_s = 1'b0;
    rd_load_s   = 1'b0;
    rd_data_s   = {W{1'b0}};
    addr_ok_s   = ({1'b0, bus.req_addr} < DEPTH_EXT);
    case (state_r)
      ST_INIT: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = cnt_r;
        mem_wdata_s = fill_pattern(cnt_r);
        if (cnt_r == LAST_IDX) begin
          state_s = ST_READY;
          cnt_s   = {AW{1'b0}};
        end else begin
          cnt_s = cnt_r + AW'(1);
        end
      end
      ST_READY: begin
        req_ready_s = !bus.init_start;
        if (bus.init_start) begin
          state_s = ST_INIT;
          cnt_s   = {AW{1'b0}};
        end else if (bus.req_valid) begin
          if (bus.req_we) begin
            // Out-of-range writes are silently dropped.
            mem_we_s = addr_ok_s;
          end else begin
            rd_load_s = 1'b1;
            rd_data_s = addr_ok_s ? mem_r[bus.req_addr] : {W{1'b0}};
          end
        end else begin
          state_s = ST_READY;
        end
      end
      default: begin
        state_s = ST_INIT;
        cnt_s   = {AW{1'b0}};
      end
    endcase
  end

  // Control state and read response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_INIT;
      cnt_r      <= {AW{1'b0}};
      rd_valid_r <= 1'b0;
      rd_data_r  <= {W{1'b0}};
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      rd_valid_r <= rd_load_s;
      if (rd_load_s) begin
        rd_data_r <= rd_data_s;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  // Storage array; contents are rebuilt by the fill sequence rather than reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign bus.init_done = (state_r == ST_READY);
  assign bus.req_ready = req_ready_s;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.rd_data   = rd_data_r;

endmodule
